joypad_ports: RTL and testbench
===============================

# joypad_ports

Controller-port block for the 2A03 core. It consumes the CPU's `$4016` write strobe and its `$4016`/`$4017` read strobes, and latches two sets of 8 raw button inputs into serial shift registers. On each port read it returns one button bit per access, emulating the standard NES pad's 4021 shift register. The block sits directly downstream of the CPU's I/O decode and feeds the CPU data-in mux during `$4016`/`$4017` reads.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: number of flops in the button-input synchronizer; minimum 2.

Ports:
- `clock` in 1: CPU clock; all state is on the rising edge.
- `nreset` in 1: reset, asynchronous, active-low.
- `addr4016w` in 1: high for each clock in which the CPU writes `$4016`.
- `strobe_data` in 1: CPU write-data bit 0; qualified by `addr4016w`.
- `naddr4016r` in 1: active-low; low for the duration of a CPU read of `$4016` (port 1).
- `naddr4017r` in 1: active-low; low for the duration of a CPU read of `$4017` (port 2).
- `buttons1` in 8: raw, asynchronous pad-1 buttons, active-high. Bit mapping: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- `buttons2` in 8: same as `buttons1`, for pad 2.
- `open_bus` in 8: last value driven on the CPU data bus.
- `data_out` out 8: read data to the CPU data-in mux.
- `strobe` out 1: current latch-strobe state.

## Operation

Reset (asynchronous, `nreset` low):
- `strobe` = 0.
- Synchronizer flops = 0.
- `sr1` = `sr2` = 8'h00.
- Read-strobe history flops `prev4016` = `prev4017` = 1.
- `data_out` = 8'h00, since both read strobes are deasserted.

Synchronizer:
- Each button bus passes through `SYNC_STAGES` flops to give `sync1` and `sync2`.
- No debounce.

Strobe register:
- When `addr4016w` = 1, `strobe` <= `strobe_data`.
- Otherwise `strobe` holds.

Shift registers `sr1`, `sr2`, 8 bits each:
- Reload: when the pre-update `strobe` = 1, `sr1` <= `sync1` and `sr2` <= `sync2` every clock. Reads do not shift while reloading.
- Read end: `end1` = `~prev4016 & naddr4016r`, i.e. the rising edge of the read strobe. `end2` is defined the same way for `naddr4017r`.
- Shift: when the pre-update `strobe` = 0 and `endN` = 1, `srN` <= {1'b1, `srN`[7:1]}.
  - Shifting happens at the end of the access, so the CPU samples the current bit first.
  - After 8 shifts the register reads as all 1s. Further reads return 1 indefinitely.
- Each port shifts independently. Simultaneous `end1` and `end2` shift both.

Read data (combinational):
- `naddr4016r` = 0: `data_out` = {`open_bus`[7:5], 4'b0000, `sr1`[0]}.
- Else `naddr4017r` = 0: `data_out` = {`open_bus`[7:5], 4'b0000, `sr2`[0]}.
- Else: `data_out` = 8'h00.
- Both read strobes low at once is illegal. Port 1 wins the mux; both ports still shift at their own read ends.

Boundary cases:
- Write and read end in the same clock: the shift/reload decision uses the old `strobe`.
  - Old `strobe` = 1: reload, no shift.
  - Old `strobe` = 0 and the write sets `strobe` = 1: the shift happens this clock and the reload starts next clock.
- Falling `strobe` (write of 0): the final reload occurs in the write clock. The registers then hold until read.
- Reset mid-read: all state clears immediately. The edge history is 1, so an ongoing low strobe produces a read end when it rises.

## Timing

- `strobe` updates one clock after `addr4016w` is sampled.
- Button to `sync` latency: `SYNC_STAGES` clocks.
- Button to `sr` latency while `strobe` = 1: `SYNC_STAGES` + 1 clocks.
- `data_out` is combinational from the strobes, `sr`, and `open_bus`. It settles in the same cycle the read strobe falls.
- The shift lands one clock after the read strobe rises.
- Back-to-back reads require the read strobe high for ≥1 clock between accesses. Otherwise no edge is detected and no shift occurs.

## Test plan

- Reset:
  - Stimulus: hold `nreset` low with random inputs.
  - Response: `data_out` = 8'h00, `strobe` = 0.
  - Then: after release, a `$4016` read with `open_bus` = 8'h00 returns 8'h00.
- Pad 1 readout:
  - Stimulus: `buttons1` = 8'h81, `open_bus` = 8'h40; write 1 then 0 to `$4016`; do 9 reads.
  - Response: 8'h41, 40, 40, 40, 40, 40, 40, 41, then 41 on the 9th read.
- Strobe held high:
  - Stimulus: `strobe` = 1; toggle `buttons1`[0] between reads of `$4016`.
  - Response: each read returns the A bit from 3 clocks earlier (`SYNC_STAGES` = 2); no shifting.
- Port independence:
  - Stimulus: `buttons1` = 8'h01, `buttons2` = 8'h02; latch; interleave reads 4017, 4016, 4017.
  - Response: bit0 values 0, 1, 1.
- Same-clock collision:
  - Stimulus: `addr4016w` with `strobe_data` = 1 coincides with the `naddr4016r` rising edge, with `strobe` = 0 before.
  - Response: `sr1` shifts once, then reloads from `sync1` on the next clock.
- Reset mid-sequence:
  - Stimulus: after 3 reads of a latched 8'hFF, pulse `nreset` low.
  - Response: `sr1` = 8'h00 immediately; the next read returns bit0 = 0.

Source files
------------

// File: rtl/joypad_ports.sv
// joypad_ports -- $4016/$4017 controller ports for the 2A03 core.
//
// Emulates two standard NES pads (4021 parallel-in/serial-out). A write to
// $4016 bit 0 sets the latch strobe; while it is high both shift registers
// reload from the synchronized buttons every clock. With the strobe low, each
// completed read of a port shifts that port's register right, filling with 1.
//
// Ports:
//   clock       CPU clock, rising edge
//   nreset      async active-low reset
//   addr4016w   CPU write of $4016 this clock
//   strobe_data CPU write-data bit 0
//   naddr4016r  active-low read of $4016 (pad 1)
//   naddr4017r  active-low read of $4017 (pad 2)
//   buttons1/2  raw async buttons, active-high (A,B,Sel,Start,U,D,L,R = bit0..7)
//   open_bus    last value on the CPU data bus
//   data_out    read data to the CPU data-in mux
//   strobe      current latch-strobe state

// Per-port lane: button synchronizer, read-end detector and 8-bit shifter.
module joypad_port_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       strobe,
  input  logic [7:0] buttons,
  input  logic       nread,
  output logic       data_bit
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  sync;
  logic [7:0]                  sr;
  logic                        prev_nread;
  logic                        read_end;

  // Plain flop chain; the pads are slow mechanical inputs, no debounce needed.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], buttons};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // History resets to 1 (idle) so a read that straddles reset still ends
  // with a shift when its strobe rises.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) prev_nread <= 1'b1;
    else         prev_nread <= nread;
  end

  // Shift on the rising edge of the read strobe, i.e. after the CPU sampled.
  assign read_end = ~prev_nread & nread;

  // strobe here is the pre-update value, so a write coinciding with a read
  // end acts on the old strobe state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)       sr <= 8'h00;
    else if (strobe)   sr <= sync;
    else if (read_end) sr <= {1'b1, sr[7:1]};
  end

  assign data_bit = sr[0];

endmodule

module joypad_ports #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       addr4016w,
  input  logic       strobe_data,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic [7:0] buttons1,
  input  logic [7:0] buttons2,
  input  logic [7:0] open_bus,
  output logic [7:0] data_out,
  output logic       strobe
);

  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0][7:0] btn;
  logic [NUM_PORTS-1:0]      nread;
  logic [NUM_PORTS-1:0]      port_bit;
  logic                      unused_open_bus;

  assign btn   = {buttons2, buttons1};
  assign nread = {naddr4017r, naddr4016r};

  // Low open-bus bits are replaced by the port response.
  assign unused_open_bus = ^open_bus[4:0];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)        strobe <= 1'b0;
    else if (addr4016w) strobe <= strobe_data;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    joypad_port_lane #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clock    (clock),
      .nreset   (nreset),
      .strobe   (strobe),
      .buttons  (btn[p]),
      .nread    (nread[p]),
      .data_bit (port_bit[p])
    );
  end

  // Port 1 wins if both strobes are (illegally) low; both lanes still shift.
  always_comb begin
    data_out = 8'h00;
    if (!naddr4016r)      data_out = {open_bus[7:5], 4'b0000, port_bit[0]};
    else if (!naddr4017r) data_out = {open_bus[7:5], 4'b0000, port_bit[1]};
  end

endmodule

// File: tb/tb_joypad_ports.sv
module tb_joypad_ports;

  logic       clock = 1'b0;
  logic       nreset;
  logic       addr4016w;
  logic       strobe_data;
  logic       naddr4016r;
  logic       naddr4017r;
  logic [7:0] buttons1;
  logic [7:0] buttons2;
  logic [7:0] open_bus;
  logic [7:0] data_out;
  logic       strobe;

  int checks = 0;
  int errors = 0;

  joypad_ports #(.SYNC_STAGES(2)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .addr4016w   (addr4016w),
    .strobe_data (strobe_data),
    .naddr4016r  (naddr4016r),
    .naddr4017r  (naddr4017r),
    .buttons1    (buttons1),
    .buttons2    (buttons2),
    .open_bus    (open_bus),
    .data_out    (data_out),
    .strobe      (strobe)
  );

  always #5 clock = ~clock;

  task automatic write4016(input logic v);
    @(negedge clock);
    addr4016w = 1'b1; strobe_data = v;
    @(negedge clock);
    addr4016w = 1'b0; strobe_data = 1'b0;
    checks++;
    if (strobe !== v) begin
      errors++;
      $display("FAIL strobe_write got %b exp %b", strobe, v);
    end
  endtask

  // One full access: strobe low across one rising edge, then high again.
  task automatic read_port(input int port, output logic [7:0] d);
    @(negedge clock);
    if (port == 1) naddr4016r = 1'b0;
    else           naddr4017r = 1'b0;
    @(posedge clock);
    #1 d = data_out;
    @(negedge clock);
    naddr4016r = 1'b1; naddr4017r = 1'b1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    naddr4016r = 1'b1; naddr4017r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      buttons1 = 8'($urandom); buttons2 = 8'($urandom);
      open_bus = 8'($urandom);
      addr4016w = 1'($urandom); strobe_data = 1'($urandom);
      #1;
      checks++;
      if (data_out !== 8'h00 || strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold data_out %h strobe %b exp 00 0", data_out, strobe);
      end
    end
    @(negedge clock);
    addr4016w = 1'b0; strobe_data = 1'b0; open_bus = 8'h00;
    nreset = 1'b1;
    begin
      logic [7:0] d;
      read_port(1, d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_first_read got %h exp 00", d);
      end
    end
  endtask

  task automatic test_pad1_readout;
    logic [7:0] exp_tab [9];
    logic [7:0] d;
    exp_tab = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    buttons1 = 8'h81; open_bus = 8'h40;
    repeat (4) @(negedge clock);
    write4016(1'b1);
    write4016(1'b0);
    for (int i = 0; i < 9; i++) begin
      read_port(1, d);
      checks++;
      if (d !== exp_tab[i]) begin
        errors++;
        $display("FAIL pad1_read%0d got %h exp %h", i, d, exp_tab[i]);
      end
    end
  endtask

  task automatic test_strobe_high;
    logic vals [5];
    logic prev_a;
    vals = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    open_bus = 8'h00; buttons1 = 8'h00;
    repeat (4) @(negedge clock);
    write4016(1'b1);
    prev_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      buttons1 = {7'b0, vals[k]};
      @(negedge clock);
      naddr4016r = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (data_out !== {7'b0, prev_a}) begin
        errors++;
        $display("FAIL strobe_hi_early%0d got %h exp %h", k, data_out, {7'b0, prev_a});
      end
      @(posedge clock);
      #1;
      checks++;
      if (data_out !== {7'b0, vals[k]}) begin
        errors++;
        $display("FAIL strobe_hi_late%0d got %h exp %h", k, data_out, {7'b0, vals[k]});
      end
      @(negedge clock);
      naddr4016r = 1'b1;
      prev_a = vals[k];
    end
    write4016(1'b0);
  endtask

  task automatic test_port_independence;
    logic [7:0] d;
    int         ports [3];
    logic [7:0] exp_tab [3];
    ports   = '{2, 1, 2};
    exp_tab = '{8'hE0, 8'hE1, 8'hE1};
    buttons1 = 8'h01; buttons2 = 8'h02; open_bus = 8'hE0;
    repeat (4) @(negedge clock);
    write4016(1'b1);
    write4016(1'b0);
    for (int i = 0; i < 3; i++) begin
      read_port(ports[i], d);
      checks++;
      if (d !== exp_tab[i]) begin
        errors++;
        $display("FAIL indep_read%0d port %0d got %h exp %h", i, ports[i], d, exp_tab[i]);
      end
    end
  endtask

  task automatic test_collision;
    open_bus = 8'h00; buttons1 = 8'h02;
    repeat (4) @(negedge clock);
    write4016(1'b1);
    write4016(1'b0);
    buttons1 = 8'h04;
    repeat (4) @(negedge clock);
    naddr4016r = 1'b0;
    @(negedge clock);
    // Read end and strobe-set write land on the same edge.
    naddr4016r = 1'b1; addr4016w = 1'b1; strobe_data = 1'b1;
    @(negedge clock);
    addr4016w = 1'b0; strobe_data = 1'b0; naddr4016r = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h01 || strobe !== 1'b1) begin
      errors++;
      $display("FAIL collision_shift data_out %h strobe %b exp 01 1", data_out, strobe);
    end
    @(posedge clock);
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL collision_reload got %h exp 00", data_out);
    end
    @(negedge clock);
    naddr4016r = 1'b1;
    write4016(1'b0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    open_bus = 8'hA0; buttons1 = 8'hFF;
    repeat (4) @(negedge clock);
    write4016(1'b1);
    write4016(1'b0);
    for (int i = 0; i < 3; i++) begin
      read_port(1, d);
      checks++;
      if (d !== 8'hA1) begin
        errors++;
        $display("FAIL rmid_read%0d got %h exp a1", i, d);
      end
    end
    write4016(1'b1);
    @(negedge clock);
    naddr4016r = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'hA1) begin
      errors++;
      $display("FAIL rmid_pre got %h exp a1", data_out);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'hA0 || strobe !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clear data_out %h strobe %b exp a0 0", data_out, strobe);
    end
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    naddr4016r = 1'b1;
    read_port(1, d);
    checks++;
    if (d !== 8'hA0) begin
      errors++;
      $display("FAIL rmid_post got %h exp a0", d);
    end
  endtask

  initial begin
    nreset = 1'b0; addr4016w = 1'b0; strobe_data = 1'b0;
    naddr4016r = 1'b1; naddr4017r = 1'b1;
    buttons1 = 8'h00; buttons2 = 8'h00; open_bus = 8'h00;
    test_reset;
    test_pad1_readout;
    test_strobe_high;
    test_port_independence;
    test_collision;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
